// File: rtl/mt_seeder.sv
// mt_seeder: expands one seed word into the N-word mersenne twister state
// using the standard initialisation recurrence. The words are streamed to the
// twister one per cycle, oldest word first. Generate requests are passed
// through only once the twister has been fully seeded.
module mt_seeder #(
    parameter int             W = 32,
    parameter int             N = 624,
    parameter logic [W-1:0]   F = 32'h6C078965
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] seed,
    input  logic         gen_req,
    output logic         load_value,
    output logic [W-1:0] value,
    output logic         gen_rv,
    output logic         busy,
    output logic         ready,
    output logic         done
);

    localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t           state_q;
    logic             load_q;
    logic [W-1:0]     value_q;
    logic             busy_q;
    logic             ready_q;
    logic             done_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     x_next;

    // One step of the MT initialisation recurrence; the product and the sum
    // wrap modulo 2^W, and the index of the current word is zero-extended.
    function automatic logic [W-1:0] next_word(input logic [W-1:0]     x,
                                               input logic [IDX_W-1:0] i);
        logic [W-1:0] mixed;
        mixed = x ^ (x >> (W - 2));
        return (F * mixed) + W'(i) + W'(1);
    endfunction

    assign x_next = next_word(value_q, idx_q);

    // Control FSM: IDLE waits for a seed, LOAD streams N words, READY opens
    // the generate gate. READY accepts start as a reseed exactly like IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            value_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_READY: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        value_q <= seed;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                S_LOAD: begin
                    // start is deliberately ignored here: a load always runs
                    // to completion unless reset intervenes.
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_READY;
                        load_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        value_q <= '0;
                        idx_q   <= '0;
                    end else begin
                        value_q <= x_next;
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ready is low whenever load_value is high, so the gate also guarantees
    // the twister never sees a load and a generate in the same cycle.
    assign gen_rv     = gen_req & ready_q;
    assign load_value = load_q;
    assign value      = value_q;
    assign busy       = busy_q;
    assign ready      = ready_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mt_seeder.sv
// Directed bench for mt_seeder: reset, known seed sequences, request gating,
// start ignored during a load, reset mid-load and the reseed path.
module tb_mt_seeder;

    localparam int          W = 32;
    localparam int          N = 624;
    localparam logic [31:0] F = 32'h6C078965;
    localparam int          CAP_MAX = N + 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] seed;
    logic         gen_req;
    logic         load_value;
    logic [W-1:0] value;
    logic         gen_rv;
    logic         busy;
    logic         ready;
    logic         done;

    int checks;
    int errors;

    logic [W-1:0] cap_words [CAP_MAX];
    int           cap_len;
    logic         cap_gen;

    mt_seeder #(.W(W), .N(N), .F(F)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .gen_req    (gen_req),
        .load_value (load_value),
        .value      (value),
        .gen_rv     (gen_rv),
        .busy       (busy),
        .ready      (ready),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exclusivity of load and generate, checked on every falling edge.
    always @(negedge clk) begin
        checks++;
        if (load_value === 1'b1 && gen_rv === 1'b1) begin
            errors++;
            $display("FAIL invariant: load_value=%b gen_rv=%b both high at %0t", load_value, gen_rv, $time);
        end
    end

    // Reference: x[i] = F*(x[i-1] ^ (x[i-1]>>30)) + i, mod 2^32.
    function automatic logic [31:0] model_word(input logic [31:0] s, input int k);
        logic [31:0] x;
        x = s;
        for (int i = 1; i <= k; i++) begin
            x = F * (x ^ (x >> 30)) + 32'(i);
        end
        return x;
    endfunction

    function automatic int model_mismatches(input logic [31:0] s);
        logic [31:0] x;
        int          bad;
        x   = s;
        bad = 0;
        for (int i = 0; i < N; i++) begin
            if (i > 0) x = F * (x ^ (x >> 30)) + 32'(i);
            if (cap_words[i] !== x) bad++;
        end
        return bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load(input logic [31:0] sd);
        seed  = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records the words on the bus while load_value is high (bounded).
    // Optionally pulses start (with alt seed) or rst at a given word index.
    task automatic capture(input int start_at, input int rst_at, input logic [31:0] alt);
        cap_len = 0;
        cap_gen = 1'b0;
        while (load_value === 1'b1 && cap_len < CAP_MAX) begin
            cap_words[cap_len] = value;
            if (gen_rv === 1'b1) cap_gen = 1'b1;
            start = (cap_len == start_at);
            if (start) seed = alt;
            rst = (cap_len == rst_at);
            tick();
            cap_len++;
            if (rst) begin
                rst = 1'b0;
                break;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; seed = '0; gen_req = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (load_value !== 1'b0) begin errors++; $display("FAIL reset_load_value: got %b expected 0", load_value); end
            checks++; if (value !== 32'h0) begin errors++; $display("FAIL reset_value: got %h expected 00000000", value); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
            checks++; if (gen_rv !== 1'b0) begin errors++; $display("FAIL reset_gen_rv: got %b expected 0", gen_rv); end
        end
        gen_req = 1'b0;
    endtask

    task automatic test_seed0();
        begin_load(32'd0);
        capture(-1, -1, 32'd0);
        checks++; if (cap_words[0] !== 32'h0) begin errors++; $display("FAIL seed0_x0: got %h expected 00000000", cap_words[0]); end
        checks++; if (cap_words[1] !== 32'h1) begin errors++; $display("FAIL seed0_x1: got %h expected 00000001", cap_words[1]); end
        checks++; if (cap_words[2] !== 32'h6C078967) begin errors++; $display("FAIL seed0_x2: got %h expected 6c078967", cap_words[2]); end
        checks++; if (cap_len !== N) begin errors++; $display("FAIL seed0_len: got %0d expected %0d", cap_len, N); end
        // cycle k+N+1: first READY cycle
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL seed0_done_rise: got %b expected 1", done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL seed0_ready_rise: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seed0_busy_end: got %b expected 0", busy); end
        checks++; if (value !== 32'h0) begin errors++; $display("FAIL seed0_value_end: got %h expected 00000000", value); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL seed0_done_pulse: got %b expected 0", done); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL seed0_ready_hold: got %b expected 1", ready); end
        end
    endtask

    task automatic test_seed5489();
        int bad;
        begin_load(32'd5489);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL s5489_ready_drop: got %b expected 0", ready); end
        capture(-1, -1, 32'd0);
        checks++; if (cap_words[0] !== 32'd5489) begin errors++; $display("FAIL s5489_x0: got %0d expected 5489", cap_words[0]); end
        checks++; if (cap_words[1] !== 32'd1301868182) begin errors++; $display("FAIL s5489_x1: got %0d expected 1301868182", cap_words[1]); end
        checks++; if (cap_len !== N) begin errors++; $display("FAIL s5489_len: got %0d expected %0d", cap_len, N); end
        bad = model_mismatches(32'd5489);
        checks++; if (bad !== 0) begin errors++; $display("FAIL s5489_words: got %0d mismatching words expected 0", bad); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL s5489_done: got %b expected 1", done); end
    endtask

    task automatic test_gating();
        rst = 1'b1; tick(); rst = 1'b0;
        gen_req = 1'b1;
        tick();
        checks++; if (gen_rv !== 1'b0) begin errors++; $display("FAIL gate_idle: got %b expected 0", gen_rv); end
        begin_load(32'd7);
        capture(-1, -1, 32'd0);
        checks++; if (cap_gen !== 1'b0) begin errors++; $display("FAIL gate_load: got %b expected 0", cap_gen); end
        checks++; if (gen_rv !== 1'b1) begin errors++; $display("FAIL gate_ready: got %b expected 1", gen_rv); end
        gen_req = 1'b0; #1;
        checks++; if (gen_rv !== 1'b0) begin errors++; $display("FAIL gate_follow_low: got %b expected 0", gen_rv); end
        gen_req = 1'b1; #1;
        checks++; if (gen_rv !== 1'b1) begin errors++; $display("FAIL gate_follow_high: got %b expected 1", gen_rv); end
        // start and gen_req together in READY: request passes this cycle only
        seed = 32'd9; start = 1'b1; #1;
        checks++; if (gen_rv !== 1'b1) begin errors++; $display("FAIL gate_both_high: got %b expected 1", gen_rv); end
        tick(); start = 1'b0;
        checks++; if (gen_rv !== 1'b0) begin errors++; $display("FAIL gate_reseed_drop: got %b expected 0", gen_rv); end
        checks++; if (value !== 32'd9) begin errors++; $display("FAIL gate_reseed_x0: got %0d expected 9", value); end
        capture(-1, -1, 32'd0);
        checks++; if (cap_len !== N) begin errors++; $display("FAIL gate_reseed_len: got %0d expected %0d", cap_len, N); end
        gen_req = 1'b0;
    endtask

    task automatic test_start_during_load();
        int bad;
        begin_load(32'd12345);
        capture(100, -1, 32'd999);
        checks++; if (cap_len !== N) begin errors++; $display("FAIL sdl_len: got %0d expected %0d", cap_len, N); end
        bad = model_mismatches(32'd12345);
        checks++; if (bad !== 0) begin errors++; $display("FAIL sdl_words: got %0d mismatching words expected 0", bad); end
        checks++; if (cap_words[101] !== model_word(32'd12345, 101)) begin errors++; $display("FAIL sdl_x101: got %h expected %h", cap_words[101], model_word(32'd12345, 101)); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sdl_ready: got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid_load();
        int bad;
        begin_load(32'd42);
        capture(-1, 300, 32'd0);
        checks++; if (cap_len !== 301) begin errors++; $display("FAIL rml_abort_len: got %0d expected 301", cap_len); end
        checks++; if (load_value !== 1'b0) begin errors++; $display("FAIL rml_load_value: got %b expected 0", load_value); end
        checks++; if (value !== 32'h0) begin errors++; $display("FAIL rml_value: got %h expected 00000000", value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rml_busy: got %b expected 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rml_ready: got %b expected 0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rml_done: got %b expected 0", done); end
        tick(); tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rml_ready_stays: got %b expected 0", ready); end
        begin_load(32'd1);
        capture(-1, -1, 32'd0);
        checks++; if (cap_words[0] !== 32'd1) begin errors++; $display("FAIL rml_x0: got %0d expected 1", cap_words[0]); end
        checks++; if (cap_len !== N) begin errors++; $display("FAIL rml_len: got %0d expected %0d", cap_len, N); end
        bad = model_mismatches(32'd1);
        checks++; if (bad !== 0) begin errors++; $display("FAIL rml_words: got %0d mismatching words expected 0", bad); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rml_ready_after: got %b expected 1", ready); end
        tick();
        // reseed with 0 from READY
        begin_load(32'd0);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rml_reseed_ready: got %b expected 0", ready); end
        checks++; if (load_value !== 1'b1) begin errors++; $display("FAIL rml_reseed_load: got %b expected 1", load_value); end
        capture(-1, -1, 32'd0);
        checks++; if (cap_words[1] !== 32'h1) begin errors++; $display("FAIL rml_reseed_x1: got %h expected 00000001", cap_words[1]); end
        checks++; if (cap_words[2] !== 32'h6C078967) begin errors++; $display("FAIL rml_reseed_x2: got %h expected 6c078967", cap_words[2]); end
        checks++; if (cap_len !== N) begin errors++; $display("FAIL rml_reseed_len: got %0d expected %0d", cap_len, N); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rml_reseed_done: got %b expected 1", done); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        seed    = '0;
        gen_req = 1'b0;
        test_reset();
        test_seed0();
        test_seed5489();
        test_gating();
        test_start_during_load();
        test_reset_mid_load();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
